multireceive: RTL and testbench
===============================

Name: multireceive

Overview:
- Receive-side counterpart of the multisend/sender pair: lives on the far FPGA and is wired to out0/out1/out2/controlOut through in0..in2/ctrl_in.
- Captures six 3-bit digit symbols, most significant first, and rebuilds the decimal value as a binary number (num = Σ dₖ·10^k).
- Presents num with a sticky done flag to the keylock compare logic.

Parameters:
- HOLD_MIN, 600000, cycles ctrl_in must stay high (after sync) before a symbol is accepted (0.05 s at 12 MHz).
- TIMEOUT, 24000000, max cycles between accepted symbols once a frame has started (2 s).
- DIGITS, 6, symbols per frame.

Ports:
- hwclk, in, 1, system clock (12 MHz).
- reset, in, 1, synchronous, active-high reset.
- enabled, in, 1, high = receive a frame; low = idle and clear.
- in0, in1, in2, in, 1 each, asynchronous symbol bits; in0 is the LSB.
- ctrl_in, in, 1, asynchronous strobe; high while the symbol is stable.
- num, out, 32, reconstructed value; holds 0 until done.
- done, out, 1, sticky; high once DIGITS symbols have been received.
- err, out, 1, sticky; set on timeout.
- busy, out, 1, high while a frame is in progress (≥1 symbol accepted, not done).

Behaviour:
- Reset (and enabled=0):
  - num=0, done=0, err=0, busy=0; accumulator, digit counter and timers cleared; FSM to IDLE.
  - Reset wins over every other event in the same cycle, including mid-frame.
- Synchronisation:
  - in0..in2 and ctrl_in each pass through a 2-flop synchroniser.
  - Symbol bits are sampled from synchronised data only.
- Symbol qualification (sub-module):
  - A hold counter increments while the synced ctrl is high and clears when it is low.
  - When the counter reaches HOLD_MIN: emit a one-cycle sym_valid with the current 3-bit sym, then saturate.
  - No further sym_valid until ctrl has been low for at least 1 cycle, giving one symbol per strobe pulse.
  - Pulses shorter than HOLD_MIN are ignored silently.
- FSM (multireceive):
  - IDLE: enabled=1 → WAIT_SYM.
  - WAIT_SYM, on sym_valid:
    - acc ← acc·10 + sym, computed as (acc<<3)+(acc<<1)+sym, 32-bit; no overflow possible, max 777777.
    - cnt ← cnt+1; busy=1; timeout counter cleared.
    - If cnt reaches DIGITS → DONE, with num ← new acc and done=1 in the same cycle.
  - WAIT_SYM with cnt>0: timeout counter increments each cycle. At TIMEOUT → ERROR with err=1, busy=0, and acc/cnt cleared.
  - The timeout counter does not run while cnt=0 (idle line is legal).
  - DONE: hold num/done; ignore further symbols; leave only on enabled=0 or reset.
  - ERROR: hold err; leave only on enabled=0 or reset.
  - enabled falling in any state → IDLE next cycle, all outputs cleared.
- Latency: done rises 1 cycle after the sym_valid of the last digit, i.e. about HOLD_MIN+3 cycles after ctrl_in rises.
- Simultaneous events: a sym_valid arriving in the same cycle the timeout hits is accepted, and the timeout is discarded.

Optional Feature:
- MULTIRECEIVE_ECHO_EN:
  - Defined: adds output ack (1 bit). ack goes high for ACK_LEN = 1200000 cycles after each accepted symbol, so the sender board can pace or confirm the transfer.
  - A new symbol during an active ack restarts its counter.
  - Undefined: no ack port, and no extra logic.

Decomposition:
- Shared package:
  - Symbol width constant SYM_W=3.
  - Default DIGITS=6.
  - Clock-rate constant CLK_HZ=12000000 and the derived HOLD_MIN/TIMEOUT defaults.
  - FSM state typedef: IDLE, WAIT_SYM, DONE, ERROR.
- Sub-module symbol_rx: synchroniser, hold counter and one-shot sym_valid/sym. It is reusable by any single-symbol receiver.

Test Plan (simulate with HOLD_MIN=8, TIMEOUT=200):
- Strobes 1,2,3,4,5,6, each held 20 cycles with 10-cycle gaps → num=123456, done=1, err=0, busy=0 after the last strobe.
- Six strobes of symbol 7 → num=777777. Then six more strobes → num unchanged, done stays 1.
- A 5-cycle ctrl glitch carrying sym=5, then digits 0,0,0,0,0,1 → num=1 (glitch ignored).
- Three valid digits, then 250 idle cycles → err=1 at cycle 200 after the third digit, done=0. Then enabled=0 → err=0.
- Reset asserted after digit 4 → all outputs 0 next cycle. A full frame 9,8→(3-bit: 1,0),… resent from scratch decodes correctly.
- ctrl held high 100 cycles → exactly one digit accepted (counter increments by 1).

Source files
------------

// File: rtl/multireceive_pkg.sv
// rtl/multireceive_pkg.sv - shared constants, FSM state type and decimal accumulate helper
package multireceive_pkg;

    localparam int SYM_W        = 3;
    localparam int DIGITS_DEF   = 6;
    localparam int CLK_HZ       = 12000000;
    localparam int HOLD_MIN_DEF = CLK_HZ / 20;
    localparam int TIMEOUT_DEF  = 2 * CLK_HZ;
`ifdef MULTIRECEIVE_ECHO_EN
    localparam int ACK_LEN_DEF  = CLK_HZ / 10;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SYM = 2'd1,
        DONE     = 2'd2,
        ERROR    = 2'd3
    } state_t;

    // acc*10 + d using shifts; the six-digit octal-symbol maximum (777777) never overflows 32 bits
    function automatic logic [31:0] mul10_add(input logic [31:0] a, input logic [SYM_W-1:0] d);
        return (a << 3) + (a << 1) + 32'(d);
    endfunction

endpackage

// File: rtl/multireceive_symbol_rx.sv
// rtl/multireceive_symbol_rx.sv - synchronised strobe qualifier emitting one sym_valid per held strobe
module multireceive_symbol_rx
    import multireceive_pkg::*;
#(
    parameter int HOLD_MIN = HOLD_MIN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] bits,
    input  logic             ctrl,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid
);

    localparam int HW = $clog2(HOLD_MIN + 1);

    logic [SYM_W:0] meta;
    logic [SYM_W:0] sync;
    logic [HW-1:0]  hold;

    wire             ctrl_s = sync[SYM_W];
    wire [SYM_W-1:0] bits_s = sync[SYM_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= '0;
            sync      <= '0;
            hold      <= '0;
            sym       <= '0;
            sym_valid <= 1'b0;
        end else begin
            meta      <= {ctrl, bits};
            sync      <= meta;
            sym_valid <= 1'b0;
            if (!ctrl_s) begin
                hold <= '0;
            end else if (hold < HW'(HOLD_MIN)) begin
                // saturating at HOLD_MIN blocks a second pulse until ctrl drops
                hold <= hold + 1'b1;
                if (hold == HW'(HOLD_MIN - 1)) begin
                    sym_valid <= 1'b1;
                    sym       <= bits_s;
                end
            end
        end
    end

endmodule

// File: rtl/multireceive.sv
// rtl/multireceive.sv - six-symbol decimal frame receiver; MULTIRECEIVE_ECHO_EN adds the ack output
module multireceive
    import multireceive_pkg::*;
#(
    parameter int HOLD_MIN = HOLD_MIN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int DIGITS   = DIGITS_DEF
`ifdef MULTIRECEIVE_ECHO_EN
    , parameter int ACK_LEN = ACK_LEN_DEF
`endif
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        enabled,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        ctrl_in,
    output logic [31:0] num,
    output logic        done,
    output logic        err,
    output logic        busy
`ifdef MULTIRECEIVE_ECHO_EN
    , output logic      ack
`endif
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYM_W-1:0] sym;
    logic             sym_valid;
    state_t           state;
    logic [31:0]      acc;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tmo;

    wire [31:0]   acc_next = mul10_add(acc, sym);
    wire [CW-1:0] cnt_next = cnt + 1'b1;
    wire          accept   = (state == WAIT_SYM) && sym_valid;

    multireceive_symbol_rx #(.HOLD_MIN(HOLD_MIN)) u_symbol_rx (
        .clk       (hwclk),
        .reset     (reset),
        .bits      ({in2, in1, in0}),
        .ctrl      (ctrl_in),
        .sym       (sym),
        .sym_valid (sym_valid)
    );

    always_ff @(posedge hwclk) begin
        if (reset || !enabled) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            tmo   <= '0;
            num   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= WAIT_SYM;
                WAIT_SYM: begin
                    // an accepted symbol takes priority over a timeout in the same cycle
                    if (sym_valid) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        tmo <= '0;
                        if (cnt_next == CW'(DIGITS)) begin
                            state <= DONE;
                            num   <= acc_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end else if (cnt != '0) begin
                        if (tmo == TW'(TIMEOUT - 1)) begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            acc   <= '0;
                            cnt   <= '0;
                            tmo   <= '0;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end
                end
                DONE:    state <= DONE;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULTIRECEIVE_ECHO_EN
    localparam int AW = $clog2(ACK_LEN + 1);
    logic [AW-1:0] ack_cnt;

    // each accepted symbol (re)starts an ACK_LEN-cycle pulse
    always_ff @(posedge hwclk) begin
        if (reset || !enabled) begin
            ack_cnt <= '0;
            ack     <= 1'b0;
        end else if (accept) begin
            ack_cnt <= AW'(ACK_LEN - 1);
            ack     <= 1'b1;
        end else if (ack_cnt != '0) begin
            ack_cnt <= ack_cnt - 1'b1;
            ack     <= 1'b1;
        end else begin
            ack <= 1'b0;
        end
    end
`else
    wire unused_accept = accept;
`endif

endmodule

// File: tb/tb_multireceive.sv
// tb/tb_multireceive.sv - randomized self-checking bench for multireceive with a decimal frame model
module tb_multireceive;

    localparam int HOLD_MIN = 8;
    localparam int TIMEOUT  = 200;
    localparam int DIGITS   = 6;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        enabled;
    logic        in0, in1, in2, ctrl_in;
    logic [31:0] num;
    logic        done, err, busy;
`ifdef MULTIRECEIVE_ECHO_EN
    logic        ack;
`endif

    int total = 0;
    int bad   = 0;

    multireceive #(.HOLD_MIN(HOLD_MIN), .TIMEOUT(TIMEOUT), .DIGITS(DIGITS)) dut (
        .hwclk   (hwclk),
        .reset   (reset),
        .enabled (enabled),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .ctrl_in (ctrl_in),
        .num     (num),
        .done    (done),
        .err     (err),
        .busy    (busy)
`ifdef MULTIRECEIVE_ECHO_EN
        , .ack   (ack)
`endif
    );

    always #5 hwclk = ~hwclk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic send_sym(input logic [2:0] s, input int len, input int gap);
        {in2, in1, in0} = s;
        ctrl_in = 1'b1;
        step(len);
        ctrl_in = 1'b0;
        step(gap);
    endtask

    task automatic restart();
        enabled = 1'b0;
        step(2);
        enabled = 1'b1;
        step(2);
    endtask

    task automatic check_outs(input string name, input logic [31:0] e_num, input logic e_done,
                              input logic e_err, input logic e_busy);
        total++;
        if ({num, done, err, busy} !== {e_num, e_done, e_err, e_busy}) begin
            bad++;
            $display("FAIL %s: got num=%0d done=%b err=%b busy=%b, want num=%0d done=%b err=%b busy=%b",
                     name, num, done, err, busy, e_num, e_done, e_err, e_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enabled = 1'b1;
        step(3);
        check_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        restart();
        for (int d = 1; d <= 6; d++) send_sym(3'(d), 20, 10);
        check_outs("basic_123456", 32'd123456, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_sevens();
        restart();
        for (int i = 0; i < 6; i++) send_sym(3'd7, 20, 10);
        check_outs("sevens", 32'd777777, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_sym(3'(i), 20, 10);
        check_outs("sevens_hold", 32'd777777, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        restart();
        send_sym(3'd5, 5, 10);
        for (int i = 0; i < 5; i++) send_sym(3'd0, 20, 10);
        send_sym(3'd1, 20, 10);
        check_outs("glitch", 32'd1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int waited;
        restart();
        for (int i = 0; i < 3; i++) send_sym(3'd4, 20, 10);
        check_outs("busy_mid", 32'd0, 1'b0, 1'b0, 1'b1);
        // the third digit was accepted about gap+HOLD_MIN-ish cycles ago; err is due ~200 after acceptance
        step(150);
        check_outs("no_early_err", 32'd0, 1'b0, 1'b0, 1'b1);
        waited = 0;
        while (err !== 1'b1 && waited < 100) begin
            step(1);
            waited++;
        end
        check_outs("timeout_err", 32'd0, 1'b0, 1'b1, 1'b0);
        step(50);
        check_outs("err_sticky", 32'd0, 1'b0, 1'b1, 1'b0);
        enabled = 1'b0;
        step(1);
        check_outs("err_clear", 32'd0, 1'b0, 1'b0, 1'b0);
        enabled = 1'b1;
        step(2);
    endtask

    task automatic test_reset_mid();
        logic [2:0]  d;
        logic [31:0] ref_num;
        restart();
        for (int i = 0; i < 4; i++) send_sym(3'd2, 20, 10);
        reset = 1'b1;
        step(1);
        check_outs("reset_mid", 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(2);
        ref_num = 0;
        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? 3'd1 : (i == 1) ? 3'd0 : 3'($urandom_range(0, 7));
            ref_num = ref_num * 10 + 32'(d);
            send_sym(d, 20, 10);
        end
        check_outs("resend", ref_num, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_long_ctrl();
        logic [2:0]  d;
        logic [31:0] ref_num;
        restart();
        send_sym(3'd3, 100, 10);
        ref_num = 3;
        check_outs("long_one", 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            d = 3'($urandom_range(0, 7));
            ref_num = ref_num * 10 + 32'(d);
            send_sym(d, 15, 10);
        end
        check_outs("long_not_done", 32'd0, 1'b0, 1'b0, 1'b1);
        d = 3'($urandom_range(0, 7));
        ref_num = ref_num * 10 + 32'(d);
        send_sym(d, 15, 10);
        check_outs("long_done", ref_num, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  d;
        logic [31:0] ref_num;
        int          accepted;
        for (int f = 0; f < 5; f++) begin
            restart();
            ref_num = 0;
            accepted = 0;
            while (accepted < DIGITS) begin
                d = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) begin
                    send_sym(d, $urandom_range(1, 5), $urandom_range(2, 12));
                end else begin
                    send_sym(d, $urandom_range(10, 30), $urandom_range(2, 15));
                    ref_num = ref_num * 10 + 32'(d);
                    accepted++;
                end
            end
            check_outs("random_frame", ref_num, 1'b1, 1'b0, 1'b0);
        end
        enabled = 1'b0;
        step(1);
        check_outs("disable_clear", 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        enabled = 1'b0;
        {in2, in1, in0} = 3'd0;
        ctrl_in = 1'b0;
        test_reset();
        test_basic();
        test_sevens();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_long_ctrl();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
